controle_fatorial_mem: RTL and testbench

// Memory-side initiator for the factorial datapath; drives memoriadedados as its only master.
// On an inicio pulse it reads operand N from data memory and computes N! iteratively with a

---
 rtl/fatorial_pkg.sv | 35 +++
 rtl/mult_desloca_soma.sv | 71 +++++++
 rtl/controle_fatorial_mem.sv | 179 +++++++++++++++++
 tb/tb_controle_fatorial_mem.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fatorial_pkg.sv
// Shared definitions for the memory-side factorial controller: widths, addresses, states, status layout.
package fatorial_pkg;

    localparam int unsigned LARGURA   = 8;
    localparam int unsigned LARG_END  = 3;
    localparam int unsigned ITERACOES = LARGURA;

    localparam logic [LARG_END-1:0] END_N      = 3'd0;
    localparam logic [LARG_END-1:0] END_RES    = 3'd1;
    localparam logic [LARG_END-1:0] END_STATUS = 3'd2;

    localparam int unsigned STATUS_BIT_OVF    = 1;
    localparam int unsigned STATUS_BIT_VALIDO = 0;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LE_N    = 3'd1,
        CARREGA = 3'd2,
        MULT    = 3'd3,
        DECR    = 3'd4,
        ESC_RES = 3'd5,
        ESC_ST  = 3'd6,
        FIM     = 3'd7
    } estado_t;

    // Status word written at the end of every run; valido is always set.
    function automatic logic [LARGURA-1:0] palavra_status(input logic ovf);
        logic [LARGURA-1:0] w;
        w                    = '0;
        w[STATUS_BIT_OVF]    = ovf;
        w[STATUS_BIT_VALIDO] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/mult_desloca_soma.sv
// 8x8 unsigned shift-add multiplier; fim pulses on the 8th cycle after ini with prod valid.
module mult_desloca_soma
    import fatorial_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ini,
    input  logic [LARGURA-1:0]     a,
    input  logic [LARGURA-1:0]     b,
    output logic [2*LARGURA-1:0]   prod,
    output logic                   fim
);

    localparam int unsigned LARG_CNT = 4;

    logic [2*LARGURA-1:0] mcand_q, mcand_d;
    logic [LARGURA-1:0]   mplier_q, mplier_d;
    logic [2*LARGURA-1:0] prod_q, prod_d;
    logic [LARG_CNT-1:0]  cnt_q, cnt_d;
    logic                 ativo_q, ativo_d;
    logic                 fim_q, fim_d;

    // Multiplier registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            ativo_q  <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            ativo_q  <= ativo_d;
            fim_q    <= fim_d;
        end
    end

    // The load cycle already performs the first partial product, so 8 steps end in time for fim.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        ativo_d  = ativo_q;
        fim_d    = 1'b0;
        if (ini) begin
            prod_d   = b[0] ? {{LARGURA{1'b0}}, a} : '0;
            mcand_d  = {{(LARGURA-1){1'b0}}, a, 1'b0};
            mplier_d = b >> 1;
            cnt_d    = LARG_CNT'(1);
            ativo_d  = 1'b1;
        end else if (ativo_q) begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + LARG_CNT'(1);
            if (cnt_q == LARG_CNT'(ITERACOES - 1)) begin
                ativo_d = 1'b0;
                fim_d   = 1'b1;
            end
        end
    end

    assign prod = prod_q;
    assign fim  = fim_q;

endmodule

// File: rtl/controle_fatorial_mem.sv
// Reads N from data memory, computes N! with the shift-add multiplier, writes result and status back.
module controle_fatorial_mem
    import fatorial_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                inicio,
    input  logic [LARGURA-1:0]  DadoLido,
    output logic [LARG_END-1:0] Endereco,
    output logic [LARGURA-1:0]  DadoEscr,
    output logic                EscMem,
    output logic                LerMem,
    output logic                ocupado,
    output logic                pronto
);

    estado_t              estado_q, estado_d;
    logic [LARGURA-1:0]   n_q, n_d;
    logic [LARGURA-1:0]   acc_q, acc_d;
    logic [LARGURA-1:0]   cont_q, cont_d;
    logic                 ovf_q, ovf_d;

    logic [LARG_END-1:0]  endereco_q, endereco_d;
    logic [LARGURA-1:0]   dado_escr_q, dado_escr_d;
    logic                 esc_mem_q, esc_mem_d;
    logic                 ler_mem_q, ler_mem_d;
    logic                 ocupado_q, ocupado_d;
    logic                 pronto_q, pronto_d;

    logic                 mul_ini_c;
    logic [LARGURA-1:0]   mul_a_c;
    logic [LARGURA-1:0]   mul_b_c;
    logic [2*LARGURA-1:0] mul_prod;
    logic                 mul_fim;
    logic [LARGURA-1:0]   cont_menos1_c;

    assign cont_menos1_c = cont_q - LARGURA'(1);

    mult_desloca_soma u_mult (
        .clock (clock),
        .reset (reset),
        .ini   (mul_ini_c),
        .a     (mul_a_c),
        .b     (mul_b_c),
        .prod  (mul_prod),
        .fim   (mul_fim)
    );

    // State, datapath and registered memory-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            n_q         <= '0;
            acc_q       <= '0;
            cont_q      <= '0;
            ovf_q       <= 1'b0;
            endereco_q  <= '0;
            dado_escr_q <= '0;
            esc_mem_q   <= 1'b0;
            ler_mem_q   <= 1'b0;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            cont_q      <= cont_d;
            ovf_q       <= ovf_d;
            endereco_q  <= endereco_d;
            dado_escr_q <= dado_escr_d;
            esc_mem_q   <= esc_mem_d;
            ler_mem_q   <= ler_mem_d;
            ocupado_q   <= ocupado_d;
            pronto_q    <= pronto_d;
        end
    end

    // Next state, datapath updates and outputs decoded from the state being entered.
    always_comb begin
        estado_d    = estado_q;
        n_d         = n_q;
        acc_d       = acc_q;
        cont_d      = cont_q;
        ovf_d       = ovf_q;
        mul_ini_c   = 1'b0;
        mul_a_c     = acc_q;
        mul_b_c     = cont_q;
        endereco_d  = '0;
        dado_escr_d = '0;
        esc_mem_d   = 1'b0;
        ler_mem_d   = 1'b0;
        ocupado_d   = 1'b0;
        pronto_d    = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (inicio) estado_d = LE_N;
            end
            LE_N: begin
                n_d      = DadoLido;
                estado_d = CARREGA;
            end
            CARREGA: begin
                acc_d  = LARGURA'(1);
                cont_d = n_q;
                ovf_d  = 1'b0;
                if (n_q <= LARGURA'(1)) begin
                    estado_d = ESC_RES;
                end else begin
                    mul_ini_c = 1'b1;
                    mul_a_c   = LARGURA'(1);
                    mul_b_c   = n_q;
                    estado_d  = MULT;
                end
            end
            MULT: begin
                if (mul_fim) begin
                    if (mul_prod[2*LARGURA-1:LARGURA] != '0) begin
                        ovf_d = 1'b1;
                        acc_d = '1;
                    end else begin
                        acc_d = mul_prod[LARGURA-1:0];
                    end
                    estado_d = DECR;
                end
            end
            DECR: begin
                // Overflow also retires through here so every multiply step costs the same 9 cycles.
                if (ovf_q) begin
                    estado_d = ESC_RES;
                end else begin
                    cont_d = cont_menos1_c;
                    if (cont_menos1_c == LARGURA'(1)) begin
                        estado_d = ESC_RES;
                    end else begin
                        mul_ini_c = 1'b1;
                        mul_a_c   = acc_q;
                        mul_b_c   = cont_menos1_c;
                        estado_d  = MULT;
                    end
                end
            end
            ESC_RES: estado_d = ESC_ST;
            ESC_ST:  estado_d = FIM;
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        ocupado_d = (estado_d != OCIOSO);
        case (estado_d)
            LE_N: begin
                endereco_d = END_N;
                ler_mem_d  = 1'b1;
            end
            ESC_RES: begin
                endereco_d  = END_RES;
                dado_escr_d = acc_d;
                esc_mem_d   = 1'b1;
            end
            ESC_ST: begin
                endereco_d  = END_STATUS;
                dado_escr_d = palavra_status(ovf_d);
                esc_mem_d   = 1'b1;
            end
            FIM: begin
                pronto_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign Endereco = endereco_q;
    assign DadoEscr = dado_escr_q;
    assign EscMem   = esc_mem_q;
    assign LerMem   = ler_mem_q;
    assign ocupado  = ocupado_q;
    assign pronto   = pronto_q;

endmodule

// File: tb/tb_controle_fatorial_mem.sv
// Bench for controle_fatorial_mem with a behavioural data memory as the only responder.
module tb_controle_fatorial_mem;

    logic       clock;
    logic       reset;
    logic       inicio;
    logic [7:0] DadoLido;
    logic [2:0] Endereco;
    logic [7:0] DadoEscr;
    logic       EscMem;
    logic       LerMem;
    logic       ocupado;
    logic       pronto;

    // memoriadedados stand-in: combinational read, write on posedge, bench preload port.
    logic [7:0] mem [0:7];
    logic       tb_we;
    logic [2:0] tb_addr;
    logic [7:0] tb_data;

    assign DadoLido = mem[Endereco];

    always @(posedge clock) begin
        if (EscMem)     mem[Endereco] <= DadoEscr;
        else if (tb_we) mem[tb_addr]  <= tb_data;
    end

    controle_fatorial_mem dut (
        .clock    (clock),
        .reset    (reset),
        .inicio   (inicio),
        .DadoLido (DadoLido),
        .Endereco (Endereco),
        .DadoEscr (DadoEscr),
        .EscMem   (EscMem),
        .LerMem   (LerMem),
        .ocupado  (ocupado),
        .pronto   (pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;
    int pronto_count = 0;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] st;
        int         lat;
    } esperado_t;

    esperado_t sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event counters on the active edge.
    always @(posedge clock) begin
        if (EscMem) wr_count++;
        if (pronto) pronto_count++;
    end

    // Bus invariants checked every cycle.
    always @(negedge clock) begin
        chk("no_rd_wr_overlap", 32'(EscMem && LerMem), 32'd0);
        chk("end_bit2_zero", 32'(Endereco[2]), 32'd0);
    end

    task automatic mem_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clock);
        tb_we   = 1'b1;
        tb_addr = addr;
        tb_data = data;
        @(negedge clock);
        tb_we   = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_endereco"}, 32'(Endereco), 32'd0);
        chk({tag, "_dadoescr"}, 32'(DadoEscr), 32'd0);
        chk({tag, "_escmem"},   32'(EscMem),   32'd0);
        chk({tag, "_lermem"},   32'(LerMem),   32'd0);
        chk({tag, "_ocupado"},  32'(ocupado),  32'd0);
        chk({tag, "_pronto"},   32'(pronto),   32'd0);
    endtask

    // One run: load N, pulse inicio, optionally re-pulse or reset mid-run, score the outcome.
    task automatic run(input logic [7:0] n, input int repulse, input int rst_at,
                       input logic [7:0] exp_res, input logic [7:0] exp_st, input int exp_lat);
        int        cyc;
        int        gaps;
        int        wr0;
        int        pr0;
        logic      done;
        logic      aborted;
        esperado_t e;
        esperado_t got;

        mem_write(3'd0, n);
        if (rst_at == 0) begin
            e.res = exp_res;
            e.st  = exp_st;
            e.lat = exp_lat;
            sb.push_back(e);
        end
        wr0 = wr_count;
        pr0 = pronto_count;
        gaps = 0;
        done = 1'b0;
        aborted = 1'b0;

        @(negedge clock);
        inicio = 1'b1;
        @(negedge clock);
        inicio = 1'b0;
        cyc = 1;
        while (1) begin
            if (rst_at != 0 && cyc == rst_at) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (!ocupado) gaps++;
            if (pronto) begin
                done = 1'b1;
                break;
            end
            if (cyc >= 200) break;
            inicio = (cyc == repulse);
            @(negedge clock);
            cyc++;
        end
        inicio = 1'b0;

        if (rst_at != 0) begin
            chk($sformatf("n%0d_abort_reached", n), 32'(aborted), 32'd1);
            repeat (50) @(negedge clock);
            chk($sformatf("n%0d_abort_no_writes", n), 32'(wr_count - wr0), 32'd0);
            chk($sformatf("n%0d_abort_no_pronto", n), 32'(pronto_count - pr0), 32'd0);
            check_idle("abort_idle");
        end else begin
            chk($sformatf("n%0d_pronto_seen", n), 32'(done), 32'd1);
            chk($sformatf("n%0d_sb_depth", n), 32'(sb.size()), 32'd1);
            got = sb.pop_front();
            chk($sformatf("n%0d_latency", n), 32'(cyc), 32'(got.lat));
            chk($sformatf("n%0d_ocupado_gaps", n), 32'(gaps), 32'd0);
            chk($sformatf("n%0d_mem_res", n), 32'(mem[1]), 32'(got.res));
            chk($sformatf("n%0d_mem_status", n), 32'(mem[2]), 32'(got.st));
            chk($sformatf("n%0d_mem_n_kept", n), 32'(mem[0]), 32'(n));
            @(negedge clock);
            chk($sformatf("n%0d_writes", n), 32'(wr_count - wr0), 32'd2);
            chk($sformatf("n%0d_pronto_count", n), 32'(pronto_count - pr0), 32'd1);
            check_idle("post_run");
        end
    endtask

    initial begin
        reset   = 1'b1;
        inicio  = 1'b0;
        tb_we   = 1'b0;
        tb_addr = '0;
        tb_data = '0;

        // Preload memory while held in reset, with inicio asserted to show it is ignored.
        mem_write(3'd0, 8'd5);
        mem_write(3'd1, 8'hAA);
        mem_write(3'd2, 8'h55);
        for (int i = 3; i < 8; i++) mem_write(3'(i), 8'h00);
        @(negedge clock);
        inicio = 1'b1;
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        inicio = 1'b0;
        repeat (10) @(negedge clock);
        check_idle("after_reset");
        chk("after_reset_mem0", 32'(mem[0]), 32'h05);
        chk("after_reset_mem1", 32'(mem[1]), 32'hAA);
        chk("after_reset_mem2", 32'(mem[2]), 32'h55);
        chk("after_reset_writes", 32'(wr_count), 32'd0);
        chk("after_reset_prontos", 32'(pronto_count), 32'd0);

        run(8'd5,   0, 0, 8'd120, 8'h01, 41);
        run(8'd0,   0, 0, 8'd1,   8'h01, 5);
        run(8'd1,   0, 0, 8'd1,   8'h01, 5);
        run(8'd3,   0, 0, 8'd6,   8'h01, 23);
        run(8'd6,   0, 0, 8'hFF,  8'h03, 41);
        run(8'd200, 0, 0, 8'hFF,  8'h03, 23);
        run(8'd4,  10, 0, 8'd24,  8'h01, 32);

        // Reset mid-run: memory keeps the previous run's results.
        run(8'd4, 0, 15, 8'd0, 8'h00, 0);
        chk("abort_mem1_kept", 32'(mem[1]), 32'd24);
        chk("abort_mem2_kept", 32'(mem[2]), 32'h01);

        run(8'd2,   0, 0, 8'd2,   8'h01, 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
